// File: rtl/reg_pipe_elastic_pkg.sv
// Shared definitions for the elastic pipeline register: default geometry and
// the helper that sizes the occupancy counter.
package reg_pipe_elastic_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 2;

  // Bits needed to count 0..depth valid stages inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_elastic_if.sv
// Handshake bundle for reg_pipe_elastic: upstream valid/ready/data, downstream
// valid/ready/data, flush request and occupancy report.
interface reg_pipe_elastic_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  import reg_pipe_elastic_pkg::*;

  localparam int OCC_W = occ_width(DEPTH);

  logic             FLUSH;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] IN_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT_DATA;
  logic [OCC_W-1:0] OCCUPANCY;

  // master is the surrounding logic that feeds and drains the pipe
  modport master (
    output FLUSH, IN_VALID, IN_DATA, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_DATA, OCCUPANCY
  );

  modport slave (
    input  FLUSH, IN_VALID, IN_DATA, OUT_READY,
    output IN_READY, OUT_VALID, OUT_DATA, OCCUPANCY
  );

endinterface

// File: rtl/reg_pipe_elastic_stage.sv
// One stage of the elastic pipe: a valid bit and data register that load from
// the predecessor whenever this stage is empty or its successor is draining.
module reg_pipe_stage #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             src_v,
  input  logic [WIDTH-1:0] src_d,
  input  logic             rdy_next,
  output logic             rdy,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  assign rdy = !v || rdy_next;

  // Data only loads with a valid source so an empty stage keeps its last value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v <= 1'b0;
      d <= INIT;
    end else if (flush) begin
      v <= 1'b0;
    end else if (rdy) begin
      v <= src_v;
      if (src_v) begin
        d <= src_d;
      end
    end
  end

endmodule

// File: rtl/reg_pipe_elastic.sv
// Elastic pipeline register: DEPTH handshaked stages with bubble collapsing,
// full throughput and a synchronous flush.
module reg_pipe_elastic
  import reg_pipe_elastic_pkg::*;
#(
  parameter int               WIDTH = DEFAULT_WIDTH,
  parameter int               DEPTH = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic              CLK,
  input  logic              RST,
  reg_pipe_elastic_if.slave bus
);

  localparam int OCC_W = occ_width(DEPTH);

  if (DEPTH < 1 || WIDTH < 1) begin : g_param_check
    $error("reg_pipe_elastic: DEPTH and WIDTH must both be at least 1");
  end

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic             in_ready;
  logic             in_xfer;
  logic [OCC_W-1:0] occ;

  // Each stage keeps its own ready net so the backward chain stays acyclic per signal.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             rdy_here;
    logic             rdy_next;
    logic             src_v;
    logic [WIDTH-1:0] src_d;

    if (k == DEPTH - 1) begin : g_tail
      assign rdy_next = bus.OUT_READY;
    end else begin : g_mid
      assign rdy_next = g_stage[k+1].rdy_here;
    end

    if (k == 0) begin : g_head
      assign src_v = in_xfer;
      assign src_d = bus.IN_DATA;
    end else begin : g_body
      assign src_v = v[k-1];
      assign src_d = d[k-1];
    end

    reg_pipe_stage #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_stage (
      .CLK      (CLK),
      .RST      (RST),
      .flush    (bus.FLUSH),
      .src_v    (src_v),
      .src_d    (src_d),
      .rdy_next (rdy_next),
      .rdy      (rdy_here),
      .v        (v[k]),
      .d        (d[k])
    );
  end

  assign in_ready = g_stage[0].rdy_here && !bus.FLUSH && !RST;
  assign in_xfer  = bus.IN_VALID && in_ready;

  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ = occ + OCC_W'(v[k]);
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = v[DEPTH-1];
  assign bus.OUT_DATA  = d[DEPTH-1];
  assign bus.OCCUPANCY = occ;

  // A stalled head item must be presented unchanged until the consumer takes it.
  a_hold_out_data: assert property (
    @(posedge CLK) disable iff (RST)
    (v[DEPTH-1] && !bus.OUT_READY) |=> $stable(d[DEPTH-1])
  );

endmodule

// File: tb/tb_reg_pipe_elastic.sv
// Bench for reg_pipe_elastic: four pipes of depth 3,1,2,4 share one stimulus
// stream and are each compared every cycle against a position-tracking queue model.
module tb_reg_pipe_elastic;

  localparam int         N        = 4;
  localparam logic [7:0] INIT_VAL = 8'hA5;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;

  logic       dut_ir  [N];
  logic       dut_ov  [N];
  logic [7:0] dut_od  [N];
  logic [7:0] dut_occ [N];

  int depth_of [N] = '{3, 1, 2, 4};

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int D = (g == 0) ? 3 : (g == 1) ? 1 : (g == 2) ? 2 : 4;

    reg_pipe_elastic_if #(.WIDTH(8), .DEPTH(D)) bus ();

    assign bus.FLUSH     = flush;
    assign bus.IN_VALID  = in_valid;
    assign bus.IN_DATA   = in_data;
    assign bus.OUT_READY = out_ready;

    reg_pipe_elastic #(
      .WIDTH (8),
      .DEPTH (D),
      .INIT  (INIT_VAL)
    ) u_dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.slave)
    );

    assign dut_ir[g]  = bus.IN_READY;
    assign dut_ov[g]  = bus.OUT_VALID;
    assign dut_od[g]  = bus.OUT_DATA;
    assign dut_occ[g] = 8'(bus.OCCUPANCY);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: items oldest-first, each with the stage index it currently sits in.
  int         m_cnt  [N];
  int         m_pos  [N][4];
  logic [7:0] m_dat  [N][4];
  logic [7:0] m_last [N];
  bit         model_live;

  int checks_total;
  int checks_passed;
  int cycle_n;

  logic       obs_ir;
  logic       obs_ov;
  logic [7:0] obs_od;
  logic [7:0] obs_occ;

  // An item advances one slot unless the item ahead of it ends the cycle in that slot.
  function automatic void model_moves(input int i, input logic ordy,
                                      output int np [4], output logic rdy0);
    int dep;
    int prev;
    dep  = depth_of[i];
    prev = -1;
    for (int j = 0; j < 4; j++) np[j] = 0;
    for (int j = 0; j < m_cnt[i]; j++) begin
      if (m_pos[i][j] == dep - 1)
        np[j] = ordy ? dep : dep - 1;
      else if (m_pos[i][j] + 1 == prev)
        np[j] = m_pos[i][j];
      else
        np[j] = m_pos[i][j] + 1;
      prev = np[j];
    end
    rdy0 = (m_cnt[i] == 0) || (prev != 0);
  endfunction

  function automatic void model_step(input int i, input logic r, input logic f,
                                     input logic iv, input logic [7:0] id,
                                     input logic ordy);
    int         np [4];
    logic       rdy0;
    int         k;
    int         dep;
    int         old_pos;
    logic [7:0] dat;
    dep = depth_of[i];
    if (r) begin
      m_cnt[i]  = 0;
      m_last[i] = INIT_VAL;
    end else if (f) begin
      m_cnt[i] = 0;
    end else begin
      model_moves(i, ordy, np, rdy0);
      k = 0;
      for (int j = 0; j < m_cnt[i]; j++) begin
        old_pos = m_pos[i][j];
        dat     = m_dat[i][j];
        if (np[j] < dep) begin
          m_pos[i][k] = np[j];
          m_dat[i][k] = dat;
          if (np[j] == dep - 1 && old_pos != dep - 1) m_last[i] = dat;
          k++;
        end
      end
      if (iv && rdy0) begin
        m_pos[i][k] = 0;
        m_dat[i][k] = id;
        if (dep == 1) m_last[i] = id;
        k++;
      end
      m_cnt[i] = k;
    end
  endfunction

  task automatic check_val(input string name, input int inst,
                           input logic [7:0] actual, input logic [7:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s inst%0d cycle %0d: got %0h, expected %0h",
                  name, inst, cycle_n, actual, expected);
  endtask

  task automatic checkOutput();
    int         np [4];
    logic       rdy0;
    logic       exp_ov;
    logic [7:0] exp_od;
    for (int i = 0; i < N; i++) begin
      model_moves(i, out_ready, np, rdy0);
      exp_ov = (m_cnt[i] > 0) && (m_pos[i][0] == depth_of[i] - 1);
      exp_od = exp_ov ? m_dat[i][0] : m_last[i];
      check_val("in_ready",  i, 8'(dut_ir[i]), 8'(!rst && !flush && rdy0));
      check_val("out_valid", i, 8'(dut_ov[i]), 8'(exp_ov));
      check_val("out_data",  i, dut_od[i], exp_od);
      check_val("occupancy", i, dut_occ[i], 8'(m_cnt[i]));
    end
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic iv,
                               input logic [7:0] id, input logic ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #2;
    if (model_live) checkOutput();
    obs_ir  = dut_ir[0];
    obs_ov  = dut_ov[0];
    obs_od  = dut_od[0];
    obs_occ = dut_occ[0];
    @(posedge clk);
    for (int i = 0; i < N; i++) model_step(i, r, f, iv, id, ordy);
    if (r) model_live = 1'b1;
    cycle_n++;
    @(negedge clk);
  endtask

  initial begin
    int         accepted;
    logic [7:0] next_val;
    logic       iv;
    checks_total  = 0;
    checks_passed = 0;
    cycle_n       = 0;
    model_live    = 1'b0;

    $display("[TB] reset");
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      check_val("lit_rst_in_ready", 0, 8'(obs_ir), 8'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_val("lit_post_rst_out_valid", 0, 8'(obs_ov), 8'd0);
    check_val("lit_post_rst_out_data",  0, obs_od, 8'hA5);
    check_val("lit_post_rst_occupancy", 0, obs_occ, 8'd0);
    check_val("lit_post_rst_in_ready",  0, 8'(obs_ir), 8'd1);

    $display("[TB] streaming");
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 1'b0, c < 4, 8'(c + 1), 1'b1);
      if (c < 4) check_val("lit_stream_in_ready", 0, 8'(obs_ir), 8'd1);
      if (c >= 3 && c <= 6) begin
        check_val("lit_stream_out_valid", 0, 8'(obs_ov), 8'd1);
        check_val("lit_stream_out_data",  0, obs_od, 8'(c - 2));
      end
      if (c == 7) check_val("lit_stream_drained", 0, 8'(obs_ov), 8'd0);
    end

    $display("[TB] backpressure");
    accepted = 0;
    next_val = 8'd10;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, next_val, 1'b0);
      if (obs_ir) begin
        accepted++;
        next_val++;
      end
    end
    check_val("lit_bp_accepted",  0, 8'(accepted), 8'd3);
    check_val("lit_bp_in_ready",  0, 8'(obs_ir), 8'd0);
    check_val("lit_bp_occupancy", 0, obs_occ, 8'd3);
    for (int c = 0; c < 8; c++) begin
      iv = (next_val < 8'd15);
      applyStimulus(1'b0, 1'b0, iv, next_val, 1'b1);
      if (iv && obs_ir) next_val++;
      if (c < 5) begin
        check_val("lit_bp_out_valid", 0, 8'(obs_ov), 8'd1);
        check_val("lit_bp_out_data",  0, obs_od, 8'(10 + c));
      end
    end
    check_val("lit_bp_all_pushed", 0, next_val, 8'd15);

    $display("[TB] bubble collapse");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h41, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h42, 1'b0);
    check_val("lit_bubble_b_accepted", 0, 8'(obs_ir), 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_val("lit_bubble_occupancy", 0, obs_occ, 8'd2);
    check_val("lit_bubble_head",      0, obs_od, 8'h41);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_val("lit_bubble_stage0_free", 0, 8'(obs_ir), 8'd1);

    $display("[TB] flush");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h43, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h44, 1'b1);
    check_val("lit_flush_full",      0, obs_occ, 8'd3);
    check_val("lit_flush_in_ready",  0, 8'(obs_ir), 8'd0);
    check_val("lit_flush_out_valid", 0, 8'(obs_ov), 8'd1);
    check_val("lit_flush_out_data",  0, obs_od, 8'h41);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_val("lit_flush_occupancy", 0, obs_occ, 8'd0);
    check_val("lit_flush_out_valid_after", 0, 8'(obs_ov), 8'd0);
    check_val("lit_flush_data_kept", 0, obs_od, 8'h41);

    $display("[TB] random");
    for (int c = 0; c < 10000; c++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 29) == 0,
                    $urandom_range(0, 9) < 6,
                    8'($urandom),
                    $urandom_range(0, 9) < 6);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
